// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between two writeback
//   sources (port 0 = ALU, port 1 = load unit) and keeps a per-register
//   busy scoreboard for the issue stage.
//
// Optional build macro: REGFILE_WRITE_ARBITER_ZERO_REG_EN
//   When defined, register 0 is hardwired to zero. Transfers to address 0
//   are accepted but never raise write_enable, and busy[0] is always 0.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req0_*                port 0 (ALU) valid/address/data, ready out
//   req1_*                port 1 (load) valid/address/data, ready out
//   reserve_valid/address issue-stage destination reservation
//   busy                  scoreboard, bit n = register n write outstanding
//   write_address/data/enable  registered register-file write port
//   contention_count      saturating count of cycles with both ports valid
module regfile_write_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  input  logic [ADDR_WIDTH-1:0]      req0_address,
  input  logic [DATA_WIDTH-1:0]      req0_data,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [ADDR_WIDTH-1:0]      req1_address,
  input  logic [DATA_WIDTH-1:0]      req1_data,
  output logic                       req1_ready,
  input  logic                       reserve_valid,
  input  logic [ADDR_WIDTH-1:0]      reserve_address,
  output logic [(2**ADDR_WIDTH)-1:0] busy,
  output logic [ADDR_WIDTH-1:0]      write_address,
  output logic [DATA_WIDTH-1:0]      write_data,
  output logic                       write_enable,
  output logic [COUNT_WIDTH-1:0]     contention_count
);

  localparam int unsigned REG_COUNT = 2**ADDR_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic                  last_grant;
  logic                  contended;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] xfer_address;
  logic [DATA_WIDTH-1:0] xfer_data;
  logic                  write_enable_next;
  logic [REG_COUNT-1:0]  busy_next;

  // Arbitration: round-robin on contention, readies held low in reset
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    contended  = req0_valid && req1_valid;
    if (rst_n) begin
      if (contended) begin
        // last_grant holds the previous contended winner; favour the other
        req0_ready = last_grant;
        req1_ready = !last_grant;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  // Selected transfer
  always_comb begin
    xfer         = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    xfer_address = req1_ready ? req1_address : req0_address;
    xfer_data    = req1_ready ? req1_data    : req0_data;
`ifdef REGFILE_WRITE_ARBITER_ZERO_REG_EN
    write_enable_next = xfer && (xfer_address != '0);
`else
    write_enable_next = xfer;
`endif
  end

  // Scoreboard next state: reserve beats clear so a newer writer stays visible
  always_comb begin
    busy_next = busy;
    for (int unsigned n = 0; n < REG_COUNT; n++) begin
      if (reserve_valid && (reserve_address == ADDR_WIDTH'(n))) begin
        busy_next[n] = 1'b1;
      end else if (xfer && (xfer_address == ADDR_WIDTH'(n))) begin
        busy_next[n] = 1'b0;
      end
    end
`ifdef REGFILE_WRITE_ARBITER_ZERO_REG_EN
    busy_next[0] = 1'b0;
`endif
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant       <= 1'b1;
      write_enable     <= 1'b0;
      write_address    <= '0;
      write_data       <= '0;
      busy             <= '0;
      contention_count <= '0;
    end else begin
      write_enable <= write_enable_next;
      if (xfer) begin
        write_address <= xfer_address;
        write_data    <= xfer_data;
      end
      // Only contended transfers move the round-robin pointer
      if (contended && xfer) begin
        last_grant <= req1_ready;
      end
      busy <= busy_next;
      if (contended && (contention_count != COUNT_MAX)) begin
        contention_count <= contention_count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter (COUNT_WIDTH=4 so the
// contention counter saturation is reachable quickly).
module tb_regfile_write_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned NR = 2**AW;

  logic          clk;
  logic          rst_n;
  logic          req0_valid;
  logic [AW-1:0] req0_address;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_address;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          reserve_valid;
  logic [AW-1:0] reserve_address;
  logic [NR-1:0] busy;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          write_enable;
  logic [CW-1:0] contention_count;

  int total = 0;
  int bad   = 0;

  regfile_write_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req0_valid      (req0_valid),
    .req0_address    (req0_address),
    .req0_data       (req0_data),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_address    (req1_address),
    .req1_data       (req1_data),
    .req1_ready      (req1_ready),
    .reserve_valid   (reserve_valid),
    .reserve_address (reserve_address),
    .busy            (busy),
    .write_address   (write_address),
    .write_data      (write_data),
    .write_enable    (write_enable),
    .contention_count(contention_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_address = '0; req0_data = '0;
    req1_valid = 1'b0; req1_address = '0; req1_data = '0;
    reserve_valid = 1'b0; reserve_address = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    tick();
    tick();
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b exp=0", write_enable); end
    total++; if (write_address !== '0) begin bad++; $display("FAIL reset_waddr got=%0d exp=0", write_address); end
    total++; if (write_data !== '0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", write_data); end
    total++; if (busy !== '0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
    total++; if (contention_count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", contention_count); end
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%0b exp=0", req0_ready); end
    req0_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    req0_valid = 1'b1; req0_address = 5'd3; req0_data = 32'hDEADBEEF;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL single_ready0 got=%0b exp=1", req0_ready); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL single_ready1 got=%0b exp=0", req1_ready); end
    tick();
    req0_valid = 1'b0;
    total++; if (write_enable !== 1'b1) begin bad++; $display("FAIL single_we got=%0b exp=1", write_enable); end
    total++; if (write_address !== 5'd3) begin bad++; $display("FAIL single_waddr got=%0d exp=3", write_address); end
    total++; if (write_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wdata got=%h exp=deadbeef", write_data); end
    tick();
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL single_we_drop got=%0b exp=0", write_enable); end
    total++; if (write_address !== 5'd3) begin bad++; $display("FAIL single_waddr_hold got=%0d exp=3", write_address); end
  endtask

  task automatic test_round_robin();
    logic exp_r0;
    do_reset();
    req0_valid = 1'b1; req0_address = 5'd1; req0_data = 32'hAAAA0001;
    req1_valid = 1'b1; req1_address = 5'd2; req1_data = 32'hBBBB0002;
    for (int i = 0; i < 4; i++) begin
      exp_r0 = (i % 2 == 0);
      #1;
      total++; if (req0_ready !== exp_r0 || req1_ready !== !exp_r0) begin
        bad++; $display("FAIL rr_grant cycle=%0d got=%0b%0b exp=%0b%0b", i, req0_ready, req1_ready, exp_r0, !exp_r0);
      end
      tick();
      total++; if (write_enable !== 1'b1 || write_address !== (exp_r0 ? 5'd1 : 5'd2)) begin
        bad++; $display("FAIL rr_write cycle=%0d got_we=%0b got_addr=%0d exp_addr=%0d", i, write_enable, write_address, exp_r0 ? 1 : 2);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    total++; if (contention_count !== 4'd4) begin bad++; $display("FAIL rr_count got=%0d exp=4", contention_count); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    reserve_valid = 1'b1; reserve_address = 5'd7;
    tick();
    reserve_valid = 1'b0;
    total++; if (busy !== 32'h0000_0080) begin bad++; $display("FAIL sb_reserve7 got=%h exp=00000080", busy); end
    tick();
    total++; if (busy !== 32'h0000_0080) begin bad++; $display("FAIL sb_hold7 got=%h exp=00000080", busy); end
    req1_valid = 1'b1; req1_address = 5'd7; req1_data = 32'h0000_0077;
    #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL sb_ready1 got=%0b exp=1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    total++; if (write_enable !== 1'b1 || write_address !== 5'd7 || busy !== '0) begin
      bad++; $display("FAIL sb_clear7 got_we=%0b got_addr=%0d got_busy=%h exp=1/7/0", write_enable, write_address, busy);
    end
    // Clearing an already-clear bit changes nothing
    req0_valid = 1'b1; req0_address = 5'd9; req0_data = 32'h9;
    tick();
    req0_valid = 1'b0;
    total++; if (busy !== '0) begin bad++; $display("FAIL sb_clear_idle got=%h exp=0", busy); end
    reserve_valid = 1'b1; reserve_address = 5'd5;
    tick();
    total++; if (busy !== 32'h0000_0020) begin bad++; $display("FAIL sb_reserve5 got=%h exp=00000020", busy); end
    // Reserve and write to 5 in the same cycle: reserve wins
    req0_valid = 1'b1; req0_address = 5'd5; req0_data = 32'h55;
    tick();
    reserve_valid = 1'b0;
    total++; if (busy !== 32'h0000_0020 || write_enable !== 1'b1) begin
      bad++; $display("FAIL sb_set_wins got_busy=%h got_we=%0b exp=00000020/1", busy, write_enable);
    end
    tick();
    req0_valid = 1'b0;
    total++; if (busy !== '0) begin bad++; $display("FAIL sb_clear5 got=%h exp=0", busy); end
  endtask

  task automatic test_saturation();
    int exp;
    do_reset();
    req0_valid = 1'b1; req0_address = 5'd1;
    req1_valid = 1'b1; req1_address = 5'd2;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp = (i + 1 > 15) ? 15 : i + 1;
      total++; if (contention_count !== CW'(exp)) begin
        bad++; $display("FAIL sat_count cycle=%0d got=%0d exp=%0d", i, contention_count, exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    logic exp_we;
    logic exp_b0;
`ifdef REGFILE_WRITE_ARBITER_ZERO_REG_EN
    exp_we = 1'b0; exp_b0 = 1'b0;
`else
    exp_we = 1'b1; exp_b0 = 1'b1;
`endif
    do_reset();
    req0_valid = 1'b1; req0_address = 5'd0; req0_data = 32'h1234;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL zero_ready0 got=%0b exp=1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    total++; if (write_enable !== exp_we) begin bad++; $display("FAIL zero_we got=%0b exp=%0b", write_enable, exp_we); end
    if (exp_we) begin
      total++; if (write_address !== 5'd0 || write_data !== 32'h1234) begin
        bad++; $display("FAIL zero_write got_addr=%0d got_data=%h exp=0/1234", write_address, write_data);
      end
    end
    reserve_valid = 1'b1; reserve_address = 5'd0;
    tick();
    reserve_valid = 1'b0;
    total++; if (busy[0] !== exp_b0) begin bad++; $display("FAIL zero_busy0 got=%0b exp=%0b", busy[0], exp_b0); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    // Contended transfer won by port 0 moves the round-robin pointer
    req0_valid = 1'b1; req0_address = 5'd4; req0_data = 32'h4444;
    req1_valid = 1'b1; req1_address = 5'd6; req1_data = 32'h6666;
    reserve_valid = 1'b1; reserve_address = 5'd6;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL mid_pre_ready0 got=%0b exp=1", req0_ready); end
    tick();
    reserve_valid = 1'b0;
    total++; if (write_enable !== 1'b1 || busy !== 32'h0000_0040) begin
      bad++; $display("FAIL mid_pre_state got_we=%0b got_busy=%h exp=1/00000040", write_enable, busy);
    end
    rst_n = 1'b0;
    #1;
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL mid_ready_in_reset got=%0b%0b exp=00", req0_ready, req1_ready);
    end
    tick();
    total++; if (write_enable !== 1'b0 || busy !== '0 || contention_count !== '0) begin
      bad++; $display("FAIL mid_reset_state got_we=%0b got_busy=%h got_cnt=%0d exp=0/0/0", write_enable, busy, contention_count);
    end
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL mid_ready_held got=%0b%0b exp=00", req0_ready, req1_ready);
    end
    rst_n = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL mid_first_grant got=%0b%0b exp=10", req0_ready, req1_ready);
    end
    tick();
    idle_inputs();
    total++; if (write_enable !== 1'b1 || write_address !== 5'd4) begin
      bad++; $display("FAIL mid_after_write got_we=%0b got_addr=%0d exp=1/4", write_enable, write_address);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #2;
    test_reset();
    test_single_write();
    test_round_robin();
    test_scoreboard();
    test_saturation();
    test_zero_reg();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
